// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_checker
//  Purpose  : Self-synchronous PRBS7 (x^7 + x^6 + 1) checker for an N-bit
//             word stream, with lock/unlock FSM and saturating bit and
//             error counters that count only while locked.
//  Revision : 1.0 - initial release
// ============================================================================
module prbs_checker #(
    parameter int N          = 1,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 32,
    parameter int BIT_W      = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    input  logic             cke,
    input  logic             clr,
    output logic             locked,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt
);

    localparam int PC_W = $clog2(N + 1);
    localparam int GS_W = $clog2(LOCK_CNT + 1);
    localparam int BS_W = $clog2(UNLOCK_CNT + 1);
    localparam int ES_W = ((ERR_W > PC_W) ? ERR_W : PC_W) + 1;
    localparam int BC_W = ((BIT_W > PC_W) ? BIT_W : PC_W) + 1;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [6:0]       hist_q;       // last 7 accepted bits, [0] is the oldest
    logic [2:0]       seen_q;       // accepted bits so far, saturating at 7
    logic [GS_W-1:0]  good_q;
    logic [BS_W-1:0]  bad_q;
    logic             err_flag_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;

    logic [N+6:0]     ext;          // history followed by the new word, oldest first
    logic [N-1:0]     err_vec;
    logic [PC_W-1:0]  err_pop;
    logic             word_bad;
    logic             eligible;
    logic [6:0]       hist_d;
    logic [2:0]       seen_d;
    logic [ES_W-1:0]  err_sum;
    logic [BC_W-1:0]  bit_sum;
    logic [ERR_W-1:0] err_cnt_d;
    logic [BIT_W-1:0] bit_cnt_d;

    assign ext = {in, hist_q};

    // Each bit is checked against the bits 6 and 7 positions earlier in the stream.
    for (genvar b = 0; b < N; b++) begin : g_err
        assign err_vec[b] = ext[b + 7] ^ ext[b + 1] ^ ext[b];
    end

    // Number of errored bits in the current word.
    always_comb begin
        err_pop = '0;
        for (int i = 0; i < N; i++) begin
            err_pop = err_pop + PC_W'(err_vec[i]);
        end
    end

    assign word_bad  = |err_vec;
    assign eligible  = (seen_q == 3'd7);
    assign hist_d    = ext[N+6:N];
    assign seen_d    = ((32'(seen_q) + N) >= 7) ? 3'd7 : (seen_q + 3'(N));

    // Saturating adds: any carry beyond the counter width pins it at all-ones.
    assign err_sum   = ES_W'(err_cnt_q) + ES_W'(err_pop);
    assign bit_sum   = BC_W'(bit_cnt_q) + BC_W'(N);
    assign err_cnt_d = (|err_sum[ES_W-1:ERR_W]) ? '1 : err_sum[ERR_W-1:0];
    assign bit_cnt_d = (|bit_sum[BC_W-1:BIT_W]) ? '1 : bit_sum[BIT_W-1:0];

    // Statistics counters: clear has priority, only words seen while locked count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (clr) begin
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else if (cke && (state_q == ST_LOCKED)) begin
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Lock FSM, history and per-word error flag; everything holds when cke is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_SEARCH;
            hist_q     <= '0;
            seen_q     <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            err_flag_q <= 1'b0;
        end else if (cke) begin
            hist_q     <= hist_d;
            seen_q     <= seen_d;
            err_flag_q <= word_bad;
            case (state_q)
                ST_SEARCH: begin
                    if (eligible) begin
                        if (word_bad) begin
                            good_q <= '0;
                        end else if (good_q == GS_W'(LOCK_CNT - 1)) begin
                            state_q <= ST_LOCKED;
                            good_q  <= '0;
                            bad_q   <= '0;
                        end else begin
                            good_q <= good_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!word_bad) begin
                        bad_q <= '0;
                    end else if (bad_q == BS_W'(UNLOCK_CNT - 1)) begin
                        state_q <= ST_SEARCH;
                        good_q  <= '0;
                        bad_q   <= '0;
                    end else begin
                        bad_q <= bad_q + 1'b1;
                    end
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

    assign locked   = (state_q == ST_LOCKED);
    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_checker
//  Purpose  : Scoreboard bench for prbs_checker (N=4, LOCK_CNT=8,
//             UNLOCK_CNT=4) with a second instance using ERR_W=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

    localparam int N   = 4;
    localparam int LCK = 8;
    localparam int ULK = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cke = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] din = '0;
    logic         locked, err_flag, locked_s, err_flag_s;
    logic [31:0]  err_cnt;
    logic [47:0]  bit_cnt, bit_cnt_s;
    logic [3:0]   err_cnt_s;

    always #5 clk = ~clk;

    prbs_checker #(.N(N), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK), .ERR_W(32), .BIT_W(48)) dut (
        .clk(clk), .rst(rst), .in(din), .cke(cke), .clr(clr),
        .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs_checker #(.N(N), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK), .ERR_W(4), .BIT_W(48)) dut_s (
        .clk(clk), .rst(rst), .in(din), .cke(cke), .clr(clr),
        .locked(locked_s), .err_flag(err_flag_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // ---------------- reference model (bit-stream level) ----------------
    bit     sq[$];          // recent accepted bits, oldest first
    int     bseen;
    bit     m_lock;
    int     good, bad;
    longint m_err, m_bits, m_err_s;
    bit     m_flag;

    typedef struct {
        bit     lk;
        bit     fl;
        longint ec;
        longint bc;
        longint es;
    } exp_t;
    exp_t sbq[$];

    task automatic model_reset();
        sq.delete();
        repeat (7) sq.push_back(1'b0);
        bseen = 0; m_lock = 0; good = 0; bad = 0;
        m_err = 0; m_bits = 0; m_err_s = 0; m_flag = 0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit k, input logic [N-1:0] w);
        int ne;
        int n;
        bit was;
        bit elig;
        if (!r) begin
            model_reset();
            return;
        end
        was = m_lock;
        ne  = 0;
        if (c) begin
            elig = (bseen >= 7);
            for (int b = 0; b < N; b++) begin
                sq.push_back(w[b]);
                n = sq.size() - 1;
                if ((sq[n] ^ sq[n-6] ^ sq[n-7]) == 1'b1) ne++;
            end
            while (sq.size() > 7) void'(sq.pop_front());
            bseen = (bseen + N > 7) ? 7 : bseen + N;
            if (m_lock) begin
                bad = (ne > 0) ? bad + 1 : 0;
                if (bad == ULK) begin
                    m_lock = 0; good = 0; bad = 0;
                end
            end else if (elig) begin
                good = (ne == 0) ? good + 1 : 0;
                if (good == LCK) begin
                    m_lock = 1; good = 0; bad = 0;
                end
            end
            m_flag = (ne > 0);
        end
        if (k) begin
            m_err = 0; m_bits = 0; m_err_s = 0;
        end else if (c && was) begin
            m_bits  += N;
            m_err   += ne;
            m_err_s  = (m_err_s + ne > 15) ? 15 : m_err_s + ne;
        end
    endtask

    // ---------------- PRBS7 source ----------------
    bit gq[$];

    function automatic bit gen_bit();
        bit nb;
        nb = gq[0] ^ gq[1];
        void'(gq.pop_front());
        gq.push_back(nb);
        return nb;
    endfunction

    function automatic logic [N-1:0] gen_word();
        logic [N-1:0] w;
        for (int b = 0; b < N; b++) w[b] = gen_bit();
        return w;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit c, input bit k, input logic [N-1:0] w);
        exp_t x;
        rst = r; cke = c; clr = k; din = w;
        @(posedge clk);
        model_step(r, c, k, w);
        x.lk = m_lock; x.fl = m_flag; x.ec = m_err; x.bc = m_bits; x.es = m_err_s;
        sbq.push_back(x);
        #1;
    endtask

    task automatic word(input bit c, input logic [N-1:0] flip);
        logic [N-1:0] w;
        if (c) w = gen_word() ^ flip;
        else   w = N'($urandom);
        drive(1'b1, c, 1'b0, w);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("sb_locked",    64'(locked),    64'(x.lk));
            chk("sb_err_flag",  64'(err_flag),  64'(x.fl));
            chk("sb_err_cnt",   64'(err_cnt),   64'(x.ec));
            chk("sb_bit_cnt",   64'(bit_cnt),   64'(x.bc));
            chk("sb_err_cnt_s", 64'(err_cnt_s), 64'(x.es));
            chk("sb_locked_s",  64'(locked_s),  64'(x.lk));
            chk("sb_bit_cnt_s", 64'(bit_cnt_s), 64'(x.bc));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit any;
        any = 0;
        for (int i = 0; i < 7; i++) begin
            gq.push_back(bit'($urandom_range(0, 1)));
            any |= gq[i];
        end
        if (!any) gq[0] = 1'b1;
        model_reset();

        // Reset held with cke toggling.
        for (int i = 0; i < 3; i++) drive(1'b0, bit'(i % 2), bit'($urandom_range(0, 1)), N'($urandom));
        chk("rst_locked",  64'(locked),  64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_bit_cnt", 64'(bit_cnt), 64'(0));

        // Clean stream: lock after word 10.
        for (int i = 1; i <= 10; i++) begin
            word(1'b1, '0);
            if (i == 9)  chk("lock_w9",  64'(locked), 64'(0));
            if (i == 10) chk("lock_w10", 64'(locked), 64'(1));
        end
        repeat (100) word(1'b1, '0);
        chk("bits_400", 64'(bit_cnt), 64'(400));
        chk("err_0",    64'(err_cnt), 64'(0));

        // Single bit flip -> three errors.
        word(1'b1, N'(1) << $urandom_range(0, N - 1));
        repeat (3) word(1'b1, '0);
        chk("flip_err3",   64'(err_cnt), 64'(3));
        chk("flip_locked", 64'(locked),  64'(1));

        // Four fully inverted words -> +15 and unlock.
        for (int i = 1; i <= 4; i++) begin
            word(1'b1, '1);
            if (i == 3) chk("inv_w3_locked", 64'(locked), 64'(1));
        end
        chk("inv_unlock",  64'(locked),    64'(0));
        chk("inv_err18",   64'(err_cnt),   64'(18));
        chk("inv_sat15",   64'(err_cnt_s), 64'(15));

        // Relock.
        repeat (12) word(1'b1, '0);
        chk("relock", 64'(locked), 64'(1));

        // clr together with cke.
        drive(1'b1, 1'b1, 1'b1, gen_word());
        chk("clr_err",    64'(err_cnt), 64'(0));
        chk("clr_bits",   64'(bit_cnt), 64'(0));
        chk("clr_locked", 64'(locked),  64'(1));
        word(1'b1, '0);
        chk("clr_next4",  64'(bit_cnt), 64'(4));

        // Mid-operation reset, then cke one cycle in three.
        drive(1'b0, 1'b1, 1'b0, gen_word());
        chk("mid_rst_locked", 64'(locked), 64'(0));
        for (int i = 1; i <= 10; i++) begin
            word(1'b1, '0);
            if (i == 10) chk("sparse_w10", 64'(locked), 64'(1));
            word(1'b0, '0);
            word(1'b0, '0);
            if (i == 9)  chk("sparse_w9",  64'(locked), 64'(0));
        end
        chk("sparse_idle_bits", 64'(bit_cnt), 64'(0));

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            bit r, c, k;
            logic [N-1:0] f, w;
            r = ($urandom_range(0, 99) != 0);
            c = ($urandom_range(0, 99) < 70);
            k = ($urandom_range(0, 99) < 3);
            f = ($urandom_range(0, 99) < 12) ? N'($urandom) : '0;
            w = c ? (gen_word() ^ f) : N'($urandom);
            drive(r, c, k, w);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
